// File: rtl/fp_to_int_pipe_pkg.sv
// Shared FP32 decode types and helpers for the float-to-integer converters.
//   rm_e          : rounding mode encoding (RNE, RTZ, RDN, RUP, RMM)
//   fp32_class_e  : operand class after decode
//   fp32_dec_t    : decoded operand (sign, unbiased exponent, mantissa, class, mode)
//   fp32_decode() : field split + classification of a raw IEEE-754 single
package fp_to_int_pipe_pkg;

  localparam int unsigned FP_EXP_W  = 8;
  localparam int unsigned FP_FRAC_W = 23;
  localparam int unsigned FP_MANT_W = 24;
  localparam int unsigned FP_E_W    = 9;    // signed unbiased exponent
  localparam int unsigned FP_BIAS   = 127;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp32_class_e;

  typedef struct packed {
    logic                 sign;
    logic [FP_E_W-1:0]    e;      // two's complement, exp - BIAS
    logic [FP_MANT_W-1:0] mant;   // {hidden 1, frac}
    fp32_class_e          cls;
    rm_e                  rm;
    logic                 uns;
  } fp32_dec_t;

  // Reserved encodings 5-7 fall back to round-to-nearest-even.
  function automatic rm_e rm_decode(input logic [2:0] rm);
    case (rm)
      3'd1:    return RM_RTZ;
      3'd2:    return RM_RDN;
      3'd3:    return RM_RUP;
      3'd4:    return RM_RMM;
      default: return RM_RNE;
    endcase
  endfunction

  // Denormals are classed as zero: they always convert to magnitude 0 without flags.
  function automatic fp32_dec_t fp32_decode(input logic [31:0] a, input logic [2:0] rm,
                                            input logic uns);
    logic [FP_EXP_W-1:0]  ex;
    logic [FP_FRAC_W-1:0] fr;
    fp32_dec_t            d;
    ex     = a[30:23];
    fr     = a[22:0];
    d.sign = a[31];
    d.e    = FP_E_W'({1'b0, ex}) - FP_E_W'(FP_BIAS);
    d.mant = {1'b1, fr};
    d.rm   = rm_decode(rm);
    d.uns  = uns;
    if (ex == '0)      d.cls = CLS_ZERO;
    else if (ex == '1) d.cls = (fr != '0) ? CLS_NAN : CLS_INF;
    else               d.cls = CLS_NORM;
    return d;
  endfunction

endpackage

// File: rtl/fp_to_int_pipe_if.sv
// Operand/result handshake bundle of the float-to-integer pipeline.
//   in_*  : operand channel (valid/ready, FP32 operand, rounding mode, signedness, tag)
//   out_* : result channel (valid/ready, integer, NV/NX flags, tag)
//   slave : converter side, master : producer/consumer side
interface fp_to_int_pipe_if #(
  parameter int unsigned INT_W = 32,
  parameter int unsigned TAG_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [2:0]       in_rm;
  logic             in_unsigned;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [INT_W-1:0] out_int;
  logic             out_invalid;
  logic             out_inexact;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_a, in_rm, in_unsigned, in_tag, out_ready,
    output in_ready, out_valid, out_int, out_invalid, out_inexact, out_tag
  );

  modport master (
    output in_valid, in_a, in_rm, in_unsigned, in_tag, out_ready,
    input  in_ready, out_valid, out_int, out_invalid, out_inexact, out_tag
  );
endinterface

// File: rtl/fp_to_int_pipe_round_inc.sv
// Round-increment decision shared by the FP converters.
//   rm_i     : rounding mode
//   sign_i   : operand sign
//   lsb_i    : lowest kept bit
//   g_i, s_i : guard and sticky bits
//   inc_o_c  : add one ulp to the truncated magnitude (combinational)
module fp_round_inc
  import fp_to_int_pipe_pkg::*;
(
  input  rm_e  rm_i,
  input  logic sign_i,
  input  logic lsb_i,
  input  logic g_i,
  input  logic s_i,
  output logic inc_o_c
);

  always_comb begin
    inc_o_c = 1'b0;
    case (rm_i)
      RM_RNE:  inc_o_c = g_i & (s_i | lsb_i);
      RM_RTZ:  inc_o_c = 1'b0;
      RM_RDN:  inc_o_c = sign_i & (g_i | s_i);
      RM_RUP:  inc_o_c = ~sign_i & (g_i | s_i);
      RM_RMM:  inc_o_c = g_i;
      default: inc_o_c = g_i & (s_i | lsb_i);
    endcase
  end

endmodule

// File: rtl/fp_to_int_pipe.sv
// Three-stage FP32 -> INT_W-bit integer converter with valid/ready flow control.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drops every in-flight operation at the next edge
//   bus        : operand/result handshake (slave side)
// Stage 1 decodes, stage 2 aligns to the integer grid, stage 3 rounds and saturates.
module fp_to_int_pipe
  import fp_to_int_pipe_pkg::*;
#(
  parameter int unsigned INT_W = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  fp_to_int_pipe_if.slave    bus
);

  localparam int unsigned FW = INT_W + FP_MANT_W;

  localparam logic [INT_W-1:0] SAT_POS_S = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] SAT_NEG_S = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] SAT_POS_U = '1;
  localparam logic [INT_W:0]   MAG_MAX_POS = {1'b0, SAT_POS_S};
  localparam logic [INT_W:0]   MAG_MAX_NEG = {1'b0, SAT_NEG_S};
  localparam logic [INT_W:0]   MAG_MAX_U   = {1'b0, SAT_POS_U};

  typedef struct packed {
    fp32_dec_t        dec;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    fp32_class_e      cls;
    logic             ovf;
    logic [INT_W:0]   ipart;
    logic             g;
    logic             s;
    rm_e              rm;
    logic             uns;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic [INT_W-1:0] res;
    logic             nv;
    logic             nx;
    logic [TAG_W-1:0] tag;
  } s3_t;

  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  logic v1_q, v2_q, v3_q;
  logic load1_c, load2_c, load3_c;
  logic [FW-1:0]  field;
  logic [INT_W:0] mag;
  logic           inc;
  logic           in_range;
  logic           special;

  // A stage may load when it is empty or its content moves on this edge.
  assign load3_c      = ~v3_q | bus.out_ready;
  assign load2_c      = ~v2_q | load3_c;
  assign load1_c      = ~v1_q | load2_c;
  assign bus.in_ready = load1_c;

  // Stage 1: decode
  always_comb begin
    s1_d     = '0;
    s1_d.dec = fp32_decode(bus.in_a, bus.in_rm, bus.in_unsigned);
    s1_d.tag = bus.in_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      s1_q <= '0;
    end else begin
      if (flush)        v1_q <= 1'b0;
      else if (load1_c) v1_q <= bus.in_valid;
      if (load1_c && bus.in_valid) s1_q <= s1_d;
    end
  end

  // Stage 2: align mantissa so the binary point sits between field[23] and field[22]
  always_comb begin
    s2_d      = '0;
    field     = '0;
    s2_d.sign = s1_q.dec.sign;
    s2_d.cls  = s1_q.dec.cls;
    s2_d.rm   = s1_q.dec.rm;
    s2_d.uns  = s1_q.dec.uns;
    s2_d.tag  = s1_q.tag;
    if (s1_q.dec.cls == CLS_NORM) begin
      if (s1_q.dec.e[FP_E_W-1]) begin
        // |x| < 1: only rounding bits survive
        s2_d.g = (s1_q.dec.e == '1);
        s2_d.s = (s1_q.dec.e != '1) | (|s1_q.dec.mant[FP_FRAC_W-1:0]);
      end else if (s1_q.dec.e >= FP_E_W'(INT_W)) begin
        s2_d.ovf = 1'b1;
      end else begin
        field      = FW'(s1_q.dec.mant) << s1_q.dec.e[6:0];
        s2_d.ipart = field[FW-1:FP_FRAC_W];
        s2_d.g     = field[FP_FRAC_W-1];
        s2_d.s     = |field[FP_FRAC_W-2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q <= 1'b0;
      s2_q <= '0;
    end else begin
      if (flush)        v2_q <= 1'b0;
      else if (load2_c) v2_q <= v1_q;
      if (load2_c && v1_q) s2_q <= s2_d;
    end
  end

  // Stage 3: round, range check, saturate
  fp_round_inc u_round_inc (
    .rm_i    (s2_q.rm),
    .sign_i  (s2_q.sign),
    .lsb_i   (s2_q.ipart[0]),
    .g_i     (s2_q.g),
    .s_i     (s2_q.s),
    .inc_o_c (inc)
  );

  always_comb begin
    s3_d     = '0;
    s3_d.tag = s2_q.tag;
    mag      = s2_q.ipart + (INT_W+1)'(inc);
    special  = (s2_q.cls == CLS_NAN) | (s2_q.cls == CLS_INF) | s2_q.ovf;
    // A negative value rounding to zero is a legal unsigned result.
    if (s2_q.uns)       in_range = (~s2_q.sign & (mag <= MAG_MAX_U)) | (mag == '0);
    else if (s2_q.sign) in_range = (mag <= MAG_MAX_NEG);
    else                in_range = (mag <= MAG_MAX_POS);
    if (special || !in_range) begin
      s3_d.nv = 1'b1;
      if ((s2_q.cls == CLS_NAN) || !s2_q.sign) s3_d.res = s2_q.uns ? SAT_POS_U : SAT_POS_S;
      else                                      s3_d.res = s2_q.uns ? INT_W'(0) : SAT_NEG_S;
    end else begin
      s3_d.nx  = s2_q.g | s2_q.s;
      s3_d.res = s2_q.sign ? (INT_W'(0) - mag[INT_W-1:0]) : mag[INT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q <= 1'b0;
      s3_q <= '0;
    end else begin
      if (flush)        v3_q <= 1'b0;
      else if (load3_c) v3_q <= v2_q;
      if (load3_c && v2_q) s3_q <= s3_d;
    end
  end

  assign bus.out_valid   = v3_q;
  assign bus.out_int     = s3_q.res;
  assign bus.out_invalid = s3_q.nv;
  assign bus.out_inexact = s3_q.nx;
  assign bus.out_tag     = s3_q.tag;

endmodule

// File: tb/tb_fp_to_int_pipe.sv
// Directed bench for fp_to_int_pipe: 32-bit instance driven through a scoreboard,
// 64-bit instance for wide-range cases.
module tb_fp_to_int_pipe;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_pass  = 0;
  int   n_total = 0;
  logic [3:0] tag_n;

  typedef struct packed {
    logic [31:0] res;
    logic        nv;
    logic        nx;
    logic [3:0]  tag;
  } exp32_t;

  exp32_t sb[$];

  fp_to_int_pipe_if #(.INT_W(32), .TAG_W(4)) b32 ();
  fp_to_int_pipe_if #(.INT_W(64), .TAG_W(4)) b64 ();

  fp_to_int_pipe #(.INT_W(32), .TAG_W(4)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b32.slave)
  );

  fp_to_int_pipe #(.INT_W(64), .TAG_W(4)) u_dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (b64.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
  endtask

  // Result monitor: compares each transfer against the oldest expected entry.
  always @(negedge clk) begin : mon
    exp32_t e;
    if (rst_n && b32.out_valid && b32.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 128'(b32.out_valid), 128'(0));
      end else begin
        e = sb.pop_front();
        chk($sformatf("result_tag%0d", e.tag),
            128'({b32.out_int, b32.out_invalid, b32.out_inexact, b32.out_tag}), 128'(e));
      end
    end
  end

  task automatic send32(input logic [31:0] a, input logic [2:0] rm, input logic uns,
                        input logic [31:0] res, input logic nv, input logic nx);
    int k;
    b32.in_valid    = 1'b1;
    b32.in_a        = a;
    b32.in_rm       = rm;
    b32.in_unsigned = uns;
    b32.in_tag      = tag_n;
    k = 0;
    @(negedge clk);
    while (!b32.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (b32.in_ready) sb.push_back({res, nv, nx, tag_n});
    else chk("accept_timeout", 128'(b32.in_ready), 128'(1));
    tag_n = tag_n + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain_pending", 128'(sb.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic run64(input logic [31:0] a, input logic [2:0] rm, input logic uns,
                       input logic [63:0] res, input logic nv, input logic nx,
                       input logic [3:0] tag);
    int k;
    b64.in_valid    = 1'b1;
    b64.in_a        = a;
    b64.in_rm       = rm;
    b64.in_unsigned = uns;
    b64.in_tag      = tag;
    @(posedge clk);
    #1;
    b64.in_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!b64.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("int64_valid", 128'(b64.out_valid), 128'(1));
    chk($sformatf("int64_tag%0d", tag),
        128'({b64.out_int, b64.out_invalid, b64.out_inexact, b64.out_tag}),
        128'({res, nv, nx, tag}));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    flush = 1'b0;
    tag_n = 4'd0;
    b32.in_valid = 1'b0; b32.in_a = '0; b32.in_rm = '0; b32.in_unsigned = 1'b0;
    b32.in_tag = '0; b32.out_ready = 1'b1;
    b64.in_valid = 1'b0; b64.in_a = '0; b64.in_rm = '0; b64.in_unsigned = 1'b0;
    b64.in_tag = '0; b64.out_ready = 1'b1;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", 128'(b32.out_valid), 128'(0));
    chk("reset_out_fields",
        128'({b32.out_int, b32.out_invalid, b32.out_inexact, b32.out_tag}), 128'(0));
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("after_reset_in_ready", 128'(b32.in_ready), 128'(1));
    chk("after_reset_out_valid", 128'(b32.out_valid), 128'(0));

    // 64-bit range
    run64(32'h5F000000, 3'd0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'd1);
    run64(32'h5F000000, 3'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 4'd2);
    run64(32'hDF000000, 3'd0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 4'd3);
    run64(32'h4F800000, 3'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 4'd4);

    // rounding, range and special operands, back to back
    send32(32'h40200000, 3'd0, 1'b0, 32'd2,        1'b0, 1'b1);
    send32(32'h40200000, 3'd4, 1'b0, 32'd3,        1'b0, 1'b1);
    send32(32'h40200000, 3'd3, 1'b0, 32'd3,        1'b0, 1'b1);
    send32(32'h40200000, 3'd1, 1'b0, 32'd2,        1'b0, 1'b1);
    send32(32'h40200000, 3'd2, 1'b0, 32'd2,        1'b0, 1'b1);
    send32(32'h3F000000, 3'd0, 1'b0, 32'd0,        1'b0, 1'b1);
    send32(32'hBFC00000, 3'd2, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1);
    send32(32'hBFC00000, 3'd1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    send32(32'hBE99999A, 3'd1, 1'b1, 32'd0,        1'b0, 1'b1);
    send32(32'h4F000000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    send32(32'h4F000000, 3'd0, 1'b1, 32'h80000000, 1'b0, 1'b0);
    send32(32'hCF000000, 3'd0, 1'b0, 32'h80000000, 1'b0, 1'b0);
    send32(32'h7FC00000, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    send32(32'hFF800000, 3'd0, 1'b1, 32'd0,        1'b1, 1'b0);
    send32(32'h40600000, 3'd6, 1'b0, 32'd4,        1'b0, 1'b1);
    send32(32'h00000001, 3'd0, 1'b0, 32'd0,        1'b0, 1'b0);
    send32(32'h80000000, 3'd0, 1'b1, 32'd0,        1'b0, 1'b0);
    send32(32'h7F800000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send32(32'h7FC00000, 3'd0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    send32(32'hBF800000, 3'd0, 1'b1, 32'd0,        1'b1, 1'b0);
    send32(32'h7F7FFFFF, 3'd0, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0);
    send32(32'hCF000001, 3'd0, 1'b0, 32'h80000000, 1'b1, 1'b0);
    send32(32'h4EFFFFFF, 3'd0, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0);
    b32.in_valid = 1'b0;
    drain();

    // burst of 6 with the consumer stalled for several cycles
    fork
      begin
        send32(32'h3F800000, 3'd0, 1'b0, 32'd1, 1'b0, 1'b0);
        send32(32'h40000000, 3'd0, 1'b0, 32'd2, 1'b0, 1'b0);
        send32(32'h40400000, 3'd0, 1'b0, 32'd3, 1'b0, 1'b0);
        send32(32'h40800000, 3'd0, 1'b0, 32'd4, 1'b0, 1'b0);
        send32(32'h40A00000, 3'd0, 1'b0, 32'd5, 1'b0, 1'b0);
        send32(32'h40C00000, 3'd0, 1'b0, 32'd6, 1'b0, 1'b0);
        b32.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 b32.out_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", 128'(b32.in_ready), 128'(0));
        chk("stall_out_valid", 128'(b32.out_valid), 128'(1));
        chk("stall_head_tag", 128'(b32.out_tag), 128'(sb[0].tag));
        @(posedge clk);
        #1 b32.out_ready = 1'b1;
      end
    join
    drain();

    // flush with all three stages occupied and an operand offered
    b32.out_ready = 1'b0;
    send32(32'h3F800000, 3'd0, 1'b0, 32'd1, 1'b0, 1'b0);
    send32(32'h40000000, 3'd0, 1'b0, 32'd2, 1'b0, 1'b0);
    send32(32'h40400000, 3'd0, 1'b0, 32'd3, 1'b0, 1'b0);
    b32.in_a = 32'h40800000;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_pipe_full", 128'(b32.out_valid), 128'(1));
    @(posedge clk);
    #1;
    flush = 1'b0;
    b32.in_valid = 1'b0;
    sb.delete();
    b32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_no_out", 128'(b32.out_valid), 128'(0));
    end

    // flush and accept in the same cycle: the operand is dropped
    @(posedge clk);
    #1;
    b32.in_valid = 1'b1;
    b32.in_a     = 32'h40A00000;
    flush        = 1'b1;
    @(negedge clk);
    chk("flush_accept_ready", 128'(b32.in_ready), 128'(1));
    @(posedge clk);
    #1;
    flush = 1'b0;
    b32.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flush_drop_no_out", 128'(b32.out_valid), 128'(0));
    end

    // asynchronous reset with results in flight
    @(posedge clk);
    #1;
    b32.out_ready = 1'b0;
    send32(32'h3F800000, 3'd0, 1'b0, 32'd1, 1'b0, 1'b0);
    send32(32'h40000000, 3'd0, 1'b0, 32'd2, 1'b0, 1'b0);
    send32(32'h40400000, 3'd0, 1'b0, 32'd3, 1'b0, 1'b0);
    b32.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_out_valid", 128'(b32.out_valid), 128'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 128'(b32.out_valid), 128'(0));
    chk("async_reset_out_fields",
        128'({b32.out_int, b32.out_invalid, b32.out_inexact, b32.out_tag}), 128'(0));
    chk("async_reset_in_ready", 128'(b32.in_ready), 128'(1));
    sb.delete();
    b32.out_ready = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send32(32'h40A00000, 3'd0, 1'b0, 32'd5, 1'b0, 1'b0);
    b32.in_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
